hyp_cordic_multi: RTL and testbench
===================================

HYP_CORDIC_MULTI -- requirements
Module: hyp_cordic_multi

Interface
REQ-001 The block SHALL have parameter WI, default 4, input integer bits including sign.
REQ-002 The block SHALL have parameter WF, default 16, input fractional bits.
REQ-003 The block SHALL have parameter WIO, default 8, output integer bits including sign.
REQ-004 The block SHALL have parameter WFO, default 16, output fractional bits.
REQ-005 The block SHALL have parameter N, default 16, range 8..24, hyperbolic iteration count.
REQ-006 The block SHALL have parameter G, default 4, internal guard fractional bits.
REQ-007 The block SHALL have port Clk, input, 1, the only clock; all logic is rising-edge.
REQ-008 The block SHALL have port Rst_n, input, 1, reset: synchronous, active-low.
REQ-009 The block SHALL have port Start, input, 1, request; sampled only in IDLE.
REQ-010 The block SHALL have port Mode, input, 2, operation select: 00 sinh/cosh, 01 exp(x)/exp(-x), 10 tanh, 11 illegal.
REQ-011 The block SHALL have port X, input, WI+WF, signed fixed-point argument.
REQ-012 The block SHALL have port Busy, output, 1, high from acceptance until Done rises.
REQ-013 The block SHALL have port Done, output, 1, result valid; level held until the next accepted Start or reset.
REQ-014 The block SHALL have port Y0, output, WIO+WFO, signed primary result: sinh, exp(x) or tanh.
REQ-015 The block SHALL have port Y1, output, WIO+WFO, signed secondary result: cosh, exp(-x), or 0 in tanh mode.
REQ-016 The block SHALL have port Ovf, output, 1, argument clamped or output saturated; valid with Done.
REQ-017 The block SHALL have port Err, output, 1, illegal Mode; valid with Done.

Function
REQ-018 States SHALL be IDLE, ROT, DIV, FIN; FIN→IDLE after one cycle, in which Done rises.
REQ-019 In IDLE with Start=1, X and Mode SHALL be captured, Done/Ovf/Err cleared, Busy set at the next edge, next state ROT (or FIN with Err=1 and Y0=Y1=0 if Mode=11).
REQ-020 Start SHALL be ignored while Busy=1; X and Mode SHALL be don't-care after the acceptance cycle.
REQ-021 |X| > 1.0 SHALL be clamped to ±1.0 before rotation, with Ovf=1.
REQ-022 ROT SHALL run hyperbolic rotation mode, iterations i=1..N, repeating i=4 and i=13 when i≤N, one micro-iteration per cycle; R = N + (N≥4) + (N≥13) cycles.
REQ-023 Initial vector SHALL be x=1/K_h (1.2074970678 rounded to WF+G fractional bits), y=0, z=clamped X; atanh(2^-i) table rounded to WF+G fractional bits, built at elaboration.
REQ-024 The internal datapath SHALL be signed, with 3 integer bits and WF+G fractional bits; shifts arithmetic; no intermediate saturation.
REQ-025 Mode 00 SHALL give Y0=y, Y1=x; mode 01 SHALL give Y0=x+y, Y1=x-y; these modes skip DIV.
REQ-026 Mode 10 SHALL enter DIV: linear CORDIC vectoring of y/x, WFO+2 cycles, quotient to Y0.
REQ-027 Results SHALL be rounded to nearest (ties away from zero) to WFO bits, then saturated to the WIO+WFO range, with saturation setting Ovf.
REQ-028 Latency from the accepting edge to Done high SHALL be R+1 cycles (modes 00/01), R+WFO+3 cycles (mode 10), or 1 cycle (Mode=11).
REQ-029 Y0, Y1, Ovf and Err SHALL be registered and stable while Done=1.
REQ-030 Start in the same cycle Done rises SHALL be ignored; Start in a cycle where Done=1 and state is IDLE SHALL be accepted.

Reset
REQ-031 With Rst_n=0 at an edge: state SHALL be IDLE, and Busy=0, Done=0, Ovf=0, Err=0, Y0=0, Y1=0.
REQ-032 Reset SHALL abort any operation in progress with no result produced; the block SHALL accept Start in the first cycle after Rst_n returns high.

Verification (WI=4, WF=16, WIO=8, WFO=16, N=16; tolerance ±2 LSB against a double-precision golden model)
REQ-033 Mode 00, X=0x00000 -> Y0=0x000000, Y1=0x010000, Ovf=0, Done after R+1=19 cycles.
REQ-034 Mode 10, X=0x08000 (0.5) -> Y0≈0x00764E, Y1=0, Ovf=0, Done after 37 cycles.
REQ-035 Mode 01, X=0x10000 (1.0) -> Y0≈0x02B7E1, Y1≈0x005E2E, Ovf=0.
REQ-036 Mode 10, X=0x18000 (1.5) -> Ovf=1, Y0≈0x00C2F9 (tanh 1.0); X=0xE8000 (-1.5) -> Y0≈0xFF3D07, Ovf=1.
REQ-037 Mode 11 -> Err=1, Y0=Y1=0, Done after 1 cycle; a Start pulse mid-ROT is ignored and the result is unchanged.
REQ-038 Rst_n=0 for one cycle mid-DIV -> Busy=0, Done=0 at the next edge; a new Start is accepted on the following edge and gives a correct result.

Source files
------------

// File: rtl/hyp_cordic_multi.sv
`default_nettype none
// ============================================================================
//  Module   : hyp_cordic_multi
//  Function : Multi-cycle hyperbolic CORDIC. Computes sinh/cosh, exp(x)/exp(-x)
//             or tanh of a signed fixed-point argument. The hyperbolic rotation
//             runs one micro-iteration per cycle; tanh adds a linear-vectoring
//             divide stage producing sinh/cosh.
//  Revision : 1.0 - initial release
// ============================================================================
module hyp_cordic_multi #(
    parameter int WI  = 4,   // input integer bits incl. sign
    parameter int WF  = 16,  // input fractional bits
    parameter int WIO = 8,   // output integer bits incl. sign
    parameter int WFO = 16,  // output fractional bits
    parameter int N   = 16,  // hyperbolic iteration count (8..24)
    parameter int G   = 4    // internal guard fractional bits
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [1:0]           Mode,
    input  logic [WI+WF-1:0]     X,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIO+WFO-1:0]   Y0,
    output logic [WIO+WFO-1:0]   Y1,
    output logic                 Ovf,
    output logic                 Err
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int FB  = WF + G;               // datapath fractional bits
    localparam int DW  = 3 + FB;               // datapath width (3 integer bits)
    localparam int IW  = WI + WF;              // argument width
    localparam int OW  = WIO + WFO;            // result width
    localparam int QF  = WFO + 2;              // quotient fractional bits
    localparam int QW  = QF + 3;               // quotient width
    localparam int DCW = $clog2(WFO + 2) + 1;  // divide step counter width
    localparam int IXW = $clog2(N + 1);        // rotation index width
    localparam int TP  = 60;                   // table build precision (bits)

    localparam logic [127:0] C_INV_GAIN_W =
        ((128'd12074970678 << FB) + 128'd5000000000) / 128'd10000000000;
    localparam logic signed [DW-1:0] C_INV_GAIN = DW'(C_INV_GAIN_W);
    localparam logic signed [DW-1:0] C_ONE      = DW'(64'sd1 <<< FB);
    localparam logic signed [IW-1:0] C_ONE_IN   = IW'(64'sd1 <<< WF);
    localparam logic signed [63:0]   C_OMAX     = (64'sd1 <<< (OW - 1)) - 64'sd1;
    localparam logic signed [63:0]   C_OMIN     = -(64'sd1 <<< (OW - 1));

    // atanh(2^-i) = sum_k 2^-i(2k+1)/(2k+1), evaluated in wide integers and
    // rounded to FB fractional bits.
    function automatic logic [63:0] atanh_fx(input int i);
        logic [127:0] acc;
        int           e;
        acc = '0;
        for (int k = 0; k < 64; k++) begin
            e = i * (2 * k + 1);
            if (e <= TP) begin
                acc = acc + ((128'd1 << (TP - e)) / 128'(2 * k + 1));
            end
        end
        acc = (acc + (128'd1 << (TP - FB - 1))) >> (TP - FB);
        return 64'(acc);
    endfunction

    // Round to nearest (ties away from zero) from frac_in to WFO fractional
    // bits, then saturate to OW bits. Returns {saturated, value}.
    function automatic logic [OW:0] rnd_sat(input logic signed [63:0] v,
                                            input int                 frac_in);
        logic signed [63:0] t;
        logic signed [63:0] half;
        logic               sat;
        if (frac_in > WFO) begin
            half = 64'sd1 <<< (frac_in - WFO - 1);
            if (v < 0) begin
                t = -((-v + half) >>> (frac_in - WFO));
            end else begin
                t = (v + half) >>> (frac_in - WFO);
            end
        end else begin
            t = v <<< (WFO - frac_in);
        end
        sat = 1'b0;
        if (t > C_OMAX) begin
            t   = C_OMAX;
            sat = 1'b1;
        end else if (t < C_OMIN) begin
            t   = C_OMIN;
            sat = 1'b1;
        end
        return {sat, OW'(t)};
    endfunction

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers and wires
    // ------------------------------------------------------------------------
    logic signed [DW-1:0] r_x;
    logic signed [DW-1:0] r_y;
    logic signed [DW-1:0] r_z;
    logic signed [QW-1:0] r_q;
    logic [IXW-1:0]       r_iter;
    logic                 r_rep;
    logic [DCW-1:0]       r_div_i;
    logic [1:0]           r_mode;
    logic                 r_clamp;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ovf;
    logic                 r_err;
    logic [OW-1:0]        r_y0;
    logic [OW-1:0]        r_y1;

    logic [DW-1:0]        w_atanh_tab [0:N];
    logic signed [DW-1:0] w_atanh_cur;
    logic signed [DW-1:0] w_x_sh;
    logic signed [DW-1:0] w_y_sh;
    logic signed [DW-1:0] w_xd_sh;
    logic signed [QW-1:0] w_qstep;
    logic signed [IW-1:0] w_xs;
    logic                 w_clamp_hi;
    logic                 w_clamp_lo;
    logic signed [DW-1:0] w_z_init;
    logic                 w_rep_needed;
    logic                 w_rot_last;
    logic                 w_div_last;
    logic signed [63:0]   w_sum;
    logic signed [63:0]   w_dif;
    logic [OW:0]          w_r0;
    logic [OW:0]          w_r1;

    // atanh table, fixed at elaboration; entry 0 is never addressed.
    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_atanh
            if (gi == 0) begin : g_unused
                assign w_atanh_tab[gi] = '0;
            end else begin : g_entry
                localparam logic [63:0] C_VAL = atanh_fx(gi);
                assign w_atanh_tab[gi] = DW'(C_VAL);
            end
        end
    endgenerate

    assign w_atanh_cur = $signed(w_atanh_tab[r_iter]);
    assign w_x_sh      = r_x >>> r_iter;
    assign w_y_sh      = r_y >>> r_iter;
    assign w_xd_sh     = r_x >>> r_div_i;
    assign w_qstep     = QW'(1) << (DCW'(QF) - r_div_i);

    // Iterations 4 and 13 are executed twice to keep the series convergent.
    assign w_rep_needed = ((r_iter == IXW'(4)) || (r_iter == IXW'(13))) && !r_rep;
    assign w_rot_last   = (r_iter == IXW'(N)) && !w_rep_needed;
    assign w_div_last   = (r_div_i == DCW'(WFO + 1));

    assign w_xs       = $signed(X);
    assign w_clamp_hi = w_xs > C_ONE_IN;
    assign w_clamp_lo = w_xs < -C_ONE_IN;

    // Argument clamped to +/-1.0 and aligned to the datapath fraction.
    always_comb begin
        w_z_init = DW'(w_xs) <<< G;
        if (w_clamp_hi) begin
            w_z_init = C_ONE;
        end else if (w_clamp_lo) begin
            w_z_init = -C_ONE;
        end
    end

    // Final result selection, rounding and saturation per mode.
    always_comb begin
        w_r0  = '0;
        w_r1  = '0;
        w_sum = 64'(r_x) + 64'(r_y);
        w_dif = 64'(r_x) - 64'(r_y);
        case (r_mode)
            2'b00: begin
                w_r0 = rnd_sat(64'(r_y), FB);
                w_r1 = rnd_sat(64'(r_x), FB);
            end
            2'b01: begin
                w_r0 = rnd_sat(w_sum, FB);
                w_r1 = rnd_sat(w_dif, FB);
            end
            2'b10: begin
                w_r0 = rnd_sat(64'(r_q), QF);
            end
            default: begin
                w_r0 = '0;
                w_r1 = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = (Mode == 2'b11) ? S_FIN : S_ROT;
                end
            end
            S_ROT: begin
                if (w_rot_last) begin
                    w_state_nxt = (r_mode == 2'b10) ? S_DIV : S_FIN;
                end
            end
            S_DIV: begin
                if (w_div_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture, rotation, division and result registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_q     <= '0;
            r_iter  <= '0;
            r_rep   <= 1'b0;
            r_div_i <= '0;
            r_mode  <= 2'b00;
            r_clamp <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_y0    <= '0;
            r_y1    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mode  <= Mode;
                        r_x     <= C_INV_GAIN;
                        r_y     <= '0;
                        r_z     <= w_z_init;
                        r_clamp <= w_clamp_hi | w_clamp_lo;
                        r_q     <= '0;
                        r_iter  <= IXW'(1);
                        r_rep   <= 1'b0;
                        r_div_i <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_ROT: begin
                    // Rotate toward z = 0: direction follows the sign of z.
                    if (r_z[DW-1]) begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atanh_cur;
                    end else begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atanh_cur;
                    end
                    if (w_rep_needed) begin
                        r_rep <= 1'b1;
                    end else begin
                        r_rep  <= 1'b0;
                        r_iter <= r_iter + IXW'(1);
                    end
                end
                S_DIV: begin
                    // Non-restoring linear vectoring: drive residual y toward 0.
                    if (!r_y[DW-1]) begin
                        r_y <= r_y - w_xd_sh;
                        r_q <= r_q + w_qstep;
                    end else begin
                        r_y <= r_y + w_xd_sh;
                        r_q <= r_q - w_qstep;
                    end
                    r_div_i <= r_div_i + DCW'(1);
                end
                S_FIN: begin
                    r_y0   <= w_r0[OW-1:0];
                    r_y1   <= w_r1[OW-1:0];
                    r_ovf  <= (r_mode != 2'b11) & (r_clamp | w_r0[OW] | w_r1[OW]);
                    r_err  <= (r_mode == 2'b11);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Y0   = r_y0;
    assign Y1   = r_y1;
    assign Ovf  = r_ovf;
    assign Err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hyp_cordic_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hyp_cordic_multi
//  Function : Self-checking bench for hyp_cordic_multi (default parameters).
//             Expected values come from a double-precision real model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hyp_cordic_multi;

    localparam int WFO = 16;
    localparam int N   = 16;
    localparam int R   = N + ((N >= 4) ? 1 : 0) + ((N >= 13) ? 1 : 0);
    localparam int NV  = 14;

    typedef struct {
        logic [1:0]  mode;
        logic [19:0] x;
        int          exp_y0;
        int          exp_y1;
        int          tol_y1;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [19:0] x;
    logic        busy;
    logic        done;
    logic [23:0] y0;
    logic [23:0] y1;
    logic        ovf;
    logic        err;

    int   n_checks;
    int   n_fail;
    vec_t sb[$];
    vec_t tbl[NV];

    hyp_cordic_multi dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .Start (start),
        .Mode  (mode),
        .X     (x),
        .Busy  (busy),
        .Done  (done),
        .Y0    (y0),
        .Y1    (y1),
        .Ovf   (ovf),
        .Err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_fx(input real f);
        real s;
        s = f * 65536.0;
        if (s >= 0.0) return $rtoi($floor(s + 0.5));
        return -$rtoi($floor(-s + 0.5));
    endfunction

    function automatic vec_t make_vec(input logic [1:0] m, input logic [19:0] xv);
        vec_t v;
        real  xr;
        real  ep;
        real  en;
        v.mode    = m;
        v.x       = xv;
        v.exp_ovf = 1'b0;
        v.exp_err = 1'b0;
        v.tol_y1  = 2;
        xr = $itor($signed(xv)) / 65536.0;
        if (xr > 1.0) begin
            xr = 1.0;
            v.exp_ovf = 1'b1;
        end else if (xr < -1.0) begin
            xr = -1.0;
            v.exp_ovf = 1'b1;
        end
        ep = $exp(xr);
        en = $exp(-xr);
        case (m)
            2'b00: begin
                v.exp_y0  = to_fx((ep - en) / 2.0);
                v.exp_y1  = to_fx((ep + en) / 2.0);
                v.exp_lat = R + 1;
            end
            2'b01: begin
                v.exp_y0  = to_fx(ep);
                v.exp_y1  = to_fx(en);
                v.exp_lat = R + 1;
            end
            2'b10: begin
                v.exp_y0  = to_fx((ep - en) / (ep + en));
                v.exp_y1  = 0;
                v.tol_y1  = 0;
                v.exp_lat = R + WFO + 3;
            end
            default: begin
                v.exp_y0  = 0;
                v.exp_y1  = 0;
                v.tol_y1  = 0;
                v.exp_ovf = 1'b0;
                v.exp_err = 1'b1;
                v.exp_lat = 1;
            end
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        n_checks++;
        d = act - exp;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Drives a request now (off-edge), lets it be accepted, then counts edges
    // until Done. Optionally pulses a spurious Start at relative cycle 'poke'.
    task automatic run_op(input logic [1:0] m, input logic [19:0] xv,
                          input int poke, input string tag, output int lat);
        start = 1'b1;
        mode  = m;
        x     = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom);
        x     = 20'($urandom);
        chk({tag, ".busy"}, int'(busy), 1, 0);
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == poke) begin
                start = 1'b1;
                mode  = 2'b11;
                x     = 20'h18000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int poke, input string tag);
        vec_t e;
        int   lat;
        sb.push_back(v);
        run_op(v.mode, v.x, poke, tag, lat);
        e = sb.pop_front();
        chk({tag, ".done"}, int'(done), 1, 0);
        chk({tag, ".lat"}, lat, e.exp_lat, 0);
        chk({tag, ".y0"}, int'($signed(y0)), e.exp_y0, 2);
        chk({tag, ".y1"}, int'($signed(y1)), e.exp_y1, e.tol_y1);
        chk({tag, ".ovf"}, int'(ovf), int'(e.exp_ovf), 0);
        chk({tag, ".err"}, int'(err), int'(e.exp_err), 0);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = make_vec(2'b00, 20'h00000);
        tbl[1]  = make_vec(2'b10, 20'h08000);
        tbl[2]  = make_vec(2'b01, 20'h10000);
        tbl[3]  = make_vec(2'b10, 20'h18000);
        tbl[4]  = make_vec(2'b10, 20'hE8000);
        tbl[5]  = make_vec(2'b00, 20'h08000);
        tbl[6]  = make_vec(2'b00, 20'hF8000);
        tbl[7]  = make_vec(2'b01, 20'hF0000);
        tbl[8]  = make_vec(2'b11, 20'h0C000);
        tbl[9]  = make_vec(2'b00, 20'h7FFFF);
        tbl[10] = make_vec(2'b01, 20'h80000);
        tbl[11] = make_vec(2'b10, 20'h10001);
        tbl[12] = make_vec(2'b00, 20'h10000);
        tbl[13] = make_vec(2'b10, 20'hF8000);

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        x     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0, 0);
        chk("rst.done", int'(done), 0, 0);
        chk("rst.ovf", int'(ovf), 0, 0);
        chk("rst.err", int'(err), 0, 0);
        chk("rst.y0", int'(y0), 0, 0);
        chk("rst.y1", int'(y1), 0, 0);
        rst_n = 1'b1;

        // Table-driven vectors, back to back (each Start lands while Done=1)
        for (int i = 0; i < NV; i++) begin
            apply_vec(tbl[i], -1, $sformatf("v%0d", i));
        end

        // Spurious Start during ROT is ignored; result then held while Done=1
        v = make_vec(2'b00, 20'h08000);
        apply_vec(v, 5, "midrot");
        repeat (3) @(posedge clk);
        #1;
        chk("hold.done", int'(done), 1, 0);
        chk("hold.busy", int'(busy), 0, 0);
        chk("hold.y0", int'($signed(y0)), v.exp_y0, 2);

        // Start held through the cycle in which Done rises is not accepted
        start = 1'b1;
        mode  = 2'b11;
        x     = 20'h00000;
        @(posedge clk);
        #1;
        mode  = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("finrise.done", int'(done), 1, 0);
        chk("finrise.busy", int'(busy), 0, 0);
        chk("finrise.err", int'(err), 1, 0);
        @(posedge clk);
        #1;
        chk("finrise.idle", int'(busy), 0, 0);

        // One-cycle reset in the middle of DIV aborts the operation
        start = 1'b1;
        mode  = 2'b10;
        x     = 20'h08000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("middiv.busy", int'(busy), 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort.busy", int'(busy), 0, 0);
        chk("abort.done", int'(done), 0, 0);
        chk("abort.y0", int'(y0), 0, 0);
        apply_vec(make_vec(2'b01, 20'hF0000), -1, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
